analog_intl_monitor: RTL and testbench

- Parametrised N-channel analog interlock checker: compares each channel's sample against per-channel over and under setpoints, with a debounce count.
- Latches faults and captures the first-fault channel and type.
- Provides a trip/clear state machine.
- Sits between the ADC sample path and the MPS interlock aggregator; setpoints and enables come from the AXI4-Lite register block.

---
 rtl/analog_intl_monitor.sv | 197 +++++++++++++++++++
 tb/tb_analog_intl_monitor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/analog_intl_monitor.sv
// analog_intl_monitor
//   N-channel analog interlock checker. Each channel's sample is compared
//   (signed, strict) against an over and an under setpoint. Every violation
//   type has its own debounce counter. A flag latches once the count reaches
//   the shared threshold. Flags are sticky. The first fault, the OR of all
//   flags and an ARMED/TRIPPED/HOLD clear handshake are reported.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_data              channel samples, channel k at [k*DATA_W +: DATA_W]
//   i_data_valid        per-channel one-cycle sample strobe
//   i_over_sp           per-channel over setpoint
//   i_under_sp          per-channel under setpoint
//   i_cnt_thresh        consecutive violating samples to trip (0 acts as 1)
//   i_ch_en             channel monitoring enable
//   i_under_en          under-check enable, also gated by i_ch_en
//   i_intl_clr          level clear request
//   o_over_flag         latched over faults
//   o_under_flag        latched under faults
//   o_intl              registered OR of all latched flags
//   o_first_ch          channel of the first fault
//   o_first_type        first fault type, 0 = over, 1 = under
//   o_first_valid       first-fault capture valid
//   o_state             0 = ARMED, 1 = TRIPPED, 2 = HOLD

// Per-channel comparator, debounce counters and sticky flags.
module analog_intl_ch #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic signed [DATA_W-1:0] data,
  input  logic                     valid,
  input  logic signed [DATA_W-1:0] over_sp,
  input  logic signed [DATA_W-1:0] under_sp,
  input  logic [CNT_W-1:0]         thresh,
  input  logic                     ch_en,
  input  logic                     under_en,
  input  logic                     kill,
  output logic                     over_set,
  output logic                     under_set,
  output logic                     over_flag,
  output logic                     under_flag
);

  logic [CNT_W-1:0] over_cnt, under_cnt, over_cnt_nxt, under_cnt_nxt;
  logic             over_viol, under_viol, under_act;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign over_viol  = data > over_sp;
  assign under_viol = data < under_sp;
  assign under_act  = ch_en && under_en;

  always_comb begin
    over_cnt_nxt  = over_cnt;
    under_cnt_nxt = under_cnt;
    if (kill || !ch_en)  over_cnt_nxt = '0;
    else if (valid)      over_cnt_nxt = over_viol ? bump(over_cnt) : '0;
    if (kill || !under_act) under_cnt_nxt = '0;
    else if (valid)         under_cnt_nxt = under_viol ? bump(under_cnt) : '0;
  end

  // >= rather than == so a threshold lowered mid-count still trips.
  assign over_set  = !kill && ch_en && valid && over_viol &&
                     (over_cnt_nxt >= thresh);
  assign under_set = !kill && under_act && valid && under_viol &&
                     (under_cnt_nxt >= thresh);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      over_cnt   <= '0;
      under_cnt  <= '0;
      over_flag  <= 1'b0;
      under_flag <= 1'b0;
    end else begin
      over_cnt  <= over_cnt_nxt;
      under_cnt <= under_cnt_nxt;
      // Disabling a channel keeps its flag; only kill drops it.
      over_flag  <= kill ? 1'b0 : (over_flag  | over_set);
      under_flag <= kill ? 1'b0 : (under_flag | under_set);
    end
  end

endmodule

module analog_intl_monitor #(
  parameter int CH_NUM = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [CH_NUM*DATA_W-1:0] i_data,
  input  logic [CH_NUM-1:0]        i_data_valid,
  input  logic [CH_NUM*DATA_W-1:0] i_over_sp,
  input  logic [CH_NUM*DATA_W-1:0] i_under_sp,
  input  logic [CNT_W-1:0]         i_cnt_thresh,
  input  logic [CH_NUM-1:0]        i_ch_en,
  input  logic [CH_NUM-1:0]        i_under_en,
  input  logic                     i_intl_clr,
  output logic [CH_NUM-1:0]        o_over_flag,
  output logic [CH_NUM-1:0]        o_under_flag,
  output logic                     o_intl,
  output logic [CH_W-1:0]          o_first_ch,
  output logic                     o_first_type,
  output logic                     o_first_valid,
  output logic [1:0]               o_state
);

  typedef enum logic [1:0] {ARMED = 2'd0, TRIPPED = 2'd1, HOLD = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  thresh_eff;
  logic [CH_NUM-1:0] over_set, under_set;
  logic              kill, any_set, to_hold;
  logic [CH_W-1:0]   first_ch_c;
  logic              first_type_c;

  assign thresh_eff = (i_cnt_thresh == '0) ? CNT_W'(1) : i_cnt_thresh;
  // Any clear request, or sitting in HOLD, zeroes counters and suppresses
  // new flags. In ARMED no flag is latched, so this also covers clear-wins.
  assign kill    = i_intl_clr || (state == HOLD);
  assign any_set = |(over_set | under_set);
  assign to_hold = (state == HOLD) || (state == TRIPPED && i_intl_clr);

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    analog_intl_ch #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .data       (i_data[g*DATA_W +: DATA_W]),
      .valid      (i_data_valid[g]),
      .over_sp    (i_over_sp[g*DATA_W +: DATA_W]),
      .under_sp   (i_under_sp[g*DATA_W +: DATA_W]),
      .thresh     (thresh_eff),
      .ch_en      (i_ch_en[g]),
      .under_en   (i_under_en[g]),
      .kill       (kill),
      .over_set   (over_set[g]),
      .under_set  (under_set[g]),
      .over_flag  (o_over_flag[g]),
      .under_flag (o_under_flag[g])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARMED:   if (!i_intl_clr && any_set) state_nxt = TRIPPED;
      TRIPPED: if (i_intl_clr)             state_nxt = HOLD;
      HOLD:    if (!i_intl_clr)            state_nxt = ARMED;
      default:                             state_nxt = ARMED;
    endcase
  end

  // Descending scan so the lowest channel is assigned last and wins;
  // over wins over under on the same channel.
  always_comb begin
    first_ch_c   = '0;
    first_type_c = 1'b0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (over_set[k] || under_set[k]) begin
        first_ch_c   = CH_W'(k);
        first_type_c = !over_set[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= ARMED;
      o_intl        <= 1'b0;
      o_first_ch    <= '0;
      o_first_type  <= 1'b0;
      o_first_valid <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_intl <= kill ? 1'b0 : |(o_over_flag | o_under_flag | over_set | under_set);
      if (to_hold) begin
        o_first_ch    <= '0;
        o_first_type  <= 1'b0;
        o_first_valid <= 1'b0;
      end else if (state == ARMED && any_set) begin
        o_first_ch    <= first_ch_c;
        o_first_type  <= first_type_c;
        o_first_valid <= 1'b1;
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_analog_intl_monitor.sv
// Directed self-checking bench for analog_intl_monitor (8 channels).
module tb_analog_intl_monitor;
  localparam int N = 8;
  localparam int DW = 32;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] data, over_sp, under_sp;
  logic [N-1:0]    valid, ch_en, under_en;
  logic [CW-1:0]   thresh;
  logic            clr;
  logic [N-1:0]    over_flag, under_flag;
  logic            intl, first_type, first_valid;
  logic [2:0]      first_ch;
  logic [1:0]      state;

  int n_chk = 0;
  int n_fail = 0;

  // {over, under, intl, first_valid, first_type, first_ch, state}
  logic [23:0] obs;
  assign obs = {over_flag, under_flag, intl, first_valid, first_type, first_ch, state};

  always #5 clk = ~clk;

  analog_intl_monitor #(.CH_NUM(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_data(data), .i_data_valid(valid),
    .i_over_sp(over_sp), .i_under_sp(under_sp), .i_cnt_thresh(thresh),
    .i_ch_en(ch_en), .i_under_en(under_en), .i_intl_clr(clr),
    .o_over_flag(over_flag), .o_under_flag(under_flag), .o_intl(intl),
    .o_first_ch(first_ch), .o_first_type(first_type),
    .o_first_valid(first_valid), .o_state(state));

  task automatic set_ch(input int ch, input int val);
    data[ch*DW +: DW] = val;
  endtask

  // One-cycle strobe; starts and ends on a falling edge.
  task automatic strobe(input logic [N-1:0] m);
    valid = m;
    @(negedge clk);
    valid = '0;
  endtask

  // Return to ARMED: TRIPPED -> HOLD -> ARMED.
  task automatic release_intl();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [23:0] e;
    rst_n = 1'b0; clr = 1'b0; valid = '0; data = '0; thresh = 16'd3;
    ch_en = '1; under_en = '1;
    for (int k = 0; k < N; k++) begin
      over_sp[k*DW +: DW]  = 1000;
      under_sp[k*DW +: DW] = -1000;
    end
    repeat (2) @(negedge clk);
    e = '0;
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_held: got %h exp %h", obs, e); end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_release: got %h exp %h", obs, e); end
  endtask

  task automatic test_basic_trip();
    logic [23:0] e;
    thresh = 16'd3;
    set_ch(2, 1001);
    strobe(8'h04); strobe(8'h04);
    e = '0;
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL basic_two_samples: got %h exp %h", obs, e); end
    strobe(8'h04);
    e = {8'h04, 8'h00, 1'b1, 1'b1, 1'b0, 3'd2, 2'd1};
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL basic_trip: got %h exp %h", obs, e); end
    release_intl();
  endtask

  task automatic test_debounce();
    logic [23:0] e;
    thresh = 16'd3;
    set_ch(0, 1001); strobe(8'h01);
    strobe(8'h01);
    set_ch(0, 1000); strobe(8'h01);
    set_ch(0, 1001); strobe(8'h01);
    strobe(8'h01);
    e = '0;
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL debounce_break: got %h exp %h", obs, e); end
    strobe(8'h01);
    e = {8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 2'd1};
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL debounce_trip: got %h exp %h", obs, e); end
    release_intl();
    set_ch(0, 0);
  endtask

  task automatic test_simultaneous();
    logic [23:0] e;
    thresh = 16'd2;
    set_ch(5, 1001); set_ch(3, -1001);
    strobe(8'h28); strobe(8'h28);
    e = {8'h20, 8'h08, 1'b1, 1'b1, 1'b1, 3'd3, 2'd1};
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL simultaneous: got %h exp %h", obs, e); end
    // A later fault in TRIPPED adds a flag but keeps the capture.
    set_ch(1, 1001);
    strobe(8'h02); strobe(8'h02);
    e = {8'h22, 8'h08, 1'b1, 1'b1, 1'b1, 3'd3, 2'd1};
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL later_fault: got %h exp %h", obs, e); end
    release_intl();
    set_ch(5, 0); set_ch(3, 0); set_ch(1, 0);
  endtask

  task automatic test_clear();
    logic [23:0] e;
    thresh = 16'd1;
    set_ch(4, 1001);
    strobe(8'h10);
    e = {8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 3'd4, 2'd1};
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL clear_pre_trip: got %h exp %h", obs, e); end
    // Clear held with violating samples still arriving.
    clr = 1'b1; valid = 8'h10;
    e = {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== e) begin n_fail++; $display("FAIL clear_hold_%0d: got %h exp %h", c, obs, e); end
    end
    clr = 1'b0; valid = '0;
    @(negedge clk);
    e = '0;
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL clear_release: got %h exp %h", obs, e); end
    thresh = 16'd2;
    strobe(8'h10);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL retrip_one: got %h exp %h", obs, e); end
    strobe(8'h10);
    e = {8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 3'd4, 2'd1};
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL retrip_two: got %h exp %h", obs, e); end
    release_intl();
    set_ch(4, 0);
    // Clear in ARMED on the sample that would reach threshold: no flag, count restarts.
    set_ch(6, 1001);
    strobe(8'h40);
    clr = 1'b1; strobe(8'h40); clr = 1'b0;
    e = '0;
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL armed_clr_wins: got %h exp %h", obs, e); end
    strobe(8'h40);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL armed_clr_restart: got %h exp %h", obs, e); end
    strobe(8'h40);
    e = {8'h40, 8'h00, 1'b1, 1'b1, 1'b0, 3'd6, 2'd1};
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL armed_clr_trip: got %h exp %h", obs, e); end
    release_intl();
    set_ch(6, 0);
  endtask

  task automatic test_boundaries();
    logic [23:0] e;
    thresh = 16'd0;
    set_ch(7, 1001);
    strobe(8'h80);
    e = {8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 3'd7, 2'd1};
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL thresh_zero: got %h exp %h", obs, e); end
    release_intl();
    set_ch(7, 0);
    thresh = 16'd1;
    set_ch(1, 1000);  strobe(8'h02);
    set_ch(1, -1000); strobe(8'h02);
    under_en[0] = 1'b0;
    set_ch(0, -2000); strobe(8'h01);
    e = '0;
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL equal_and_under_dis: got %h exp %h", obs, e); end
    under_en[0] = 1'b1; set_ch(0, 0);
    under_sp[1*DW +: DW] = -50;
    set_ch(1, -51);
    strobe(8'h02);
    e = {8'h00, 8'h02, 1'b1, 1'b1, 1'b1, 3'd1, 2'd1};
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL negative_under: got %h exp %h", obs, e); end
    ch_en[1] = 1'b0;
    strobe(8'h02); strobe(8'h02);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL disabled_keeps_flag: got %h exp %h", obs, e); end
    ch_en[1] = 1'b1;
    release_intl();
    under_sp[1*DW +: DW] = -1000;
    set_ch(1, 0);
  endtask

  task automatic test_async_reset();
    logic [23:0] e;
    thresh = 16'd3;
    set_ch(2, 1001);
    strobe(8'h04); strobe(8'h04);
    #2 rst_n = 1'b0;
    #1;
    e = '0;
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL async_mid_count: got %h exp %h", obs, e); end
    @(negedge clk) rst_n = 1'b1;
    strobe(8'h04);
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL async_count_cleared: got %h exp %h", obs, e); end
    strobe(8'h04); strobe(8'h04);
    e = {8'h04, 8'h00, 1'b1, 1'b1, 1'b0, 3'd2, 2'd1};
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL async_pre_trip: got %h exp %h", obs, e); end
    #2 rst_n = 1'b0;
    #1;
    e = '0;
    n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL async_tripped: got %h exp %h", obs, e); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_trip();
    test_debounce();
    test_simultaneous();
    test_clear();
    test_boundaries();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
